// File: rtl/jb_aes_iter_encrypt_ctrl.sv
// Iterative AES-128 encryptor: one shared round datapath, on-the-fly key expansion and Rcon.
// Optional `JB_AES_ITER_ABORT_EN adds an abort input that cancels the block in flight.
module jb_aes_iter_encrypt_ctrl #(
  parameter int NUM_ROUNDS    = 10,
  parameter bit CLEAR_ON_DONE = 1'b1
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] blockin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] blockout,
  output logic         busy,
  output logic [3:0]   round_idx
`ifdef JB_AES_ITER_ABORT_EN
  ,
  input  logic         abort
`endif
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   round_idx_q, round_idx_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] rk_q, rk_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] blockout_q, blockout_d;
  logic [127:0] sr_w, mc_w, nk_w;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] shift_rows_sub(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127-8*(4*c+w) -: 8] = sbox(s[127-8*(4*((c+w)%4)+w) -: 8]);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] m;
    logic [7:0] a0, a1, a2, a3;
    m = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      m[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return m;
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rc, 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign sr_w = shift_rows_sub(blk_q);
  assign mc_w = mix_columns(sr_w);
  assign nk_w = expand_key(rk_q, rcon_q);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      fsm_q       <= IDLE;
      round_idx_q <= 4'd0;
      blk_q       <= '0;
      rk_q        <= '0;
      rcon_q      <= 8'h01;
      blockout_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      round_idx_q <= round_idx_d;
      blk_q       <= blk_d;
      rk_q        <= rk_d;
      rcon_q      <= rcon_d;
      blockout_q  <= blockout_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    round_idx_d = round_idx_q;
    blk_d       = blk_q;
    rk_d        = rk_q;
    rcon_d      = rcon_q;
    blockout_d  = blockout_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          blk_d       = blockin ^ key;
          rk_d        = key;
          rcon_d      = 8'h01;
          round_idx_d = 4'd1;
          fsm_d       = ROUND;
        end
      end
      ROUND: begin
        rk_d        = nk_w;
        rcon_d      = xtime(rcon_q);
        round_idx_d = round_idx_q + 4'd1;
        if (round_idx_q == 4'(NUM_ROUNDS)) begin
          blk_d       = sr_w ^ nk_w;
          blockout_d  = sr_w ^ nk_w;
          round_idx_d = 4'd0;
          fsm_d       = DONE;
        end else begin
          blk_d = mc_w ^ nk_w;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
          if (CLEAR_ON_DONE) begin
            blk_d = '0;
            rk_d  = '0;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
`ifdef JB_AES_ITER_ABORT_EN
    // Abort wins over retirement and over the final round; blockout keeps the previous result.
    if (abort && fsm_q != IDLE) begin
      fsm_d       = IDLE;
      round_idx_d = 4'd0;
      blk_d       = '0;
      rk_d        = '0;
      rcon_d      = 8'h01;
      blockout_d  = blockout_q;
    end
`endif
  end

  always_comb begin
    in_ready  = (fsm_q == IDLE);
    out_valid = (fsm_q == DONE);
    busy      = (fsm_q == ROUND) || (fsm_q == DONE);
    round_idx = round_idx_q;
    blockout  = blockout_q;
  end

endmodule

// File: tb/tb_jb_aes_iter_encrypt_ctrl.sv
// Scoreboard bench for jb_aes_iter_encrypt_ctrl: byte-array AES-128 reference model,
// directed FIPS-197 vectors, backpressure, reset, optional abort, and random blocks.
module tb_jb_aes_iter_encrypt_ctrl;

  logic         clk;
  logic         nRst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key;
  logic [127:0] blockin;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] blockout;
  logic         busy;
  logic [3:0]   round_idx;
`ifdef JB_AES_ITER_ABORT_EN
  logic         abort;
`endif

  jb_aes_iter_encrypt_ctrl dut (
    .clk(clk), .nRst(nRst), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .blockin(blockin), .out_valid(out_valid), .out_ready(out_ready),
    .blockout(blockout), .busy(busy), .round_idx(round_idx)
`ifdef JB_AES_ITER_ABORT_EN
    , .abort(abort)
`endif
  );

  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  exp_t         sb_q[$];
  logic [7:0]   sbox_t[256];
  logic [127:0] last_ct;
  int           cyc;
  int           acc_cyc;
  int           ready_mode;
  int           n_checks;
  int           n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // out_ready: 0 = held low, 1 = held high, 2 = random each cycle
  always @(posedge clk) begin
    #2;
    if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
    else                 out_ready = (ready_mode == 1);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]  s[16];
    logic [7:0]  t[16];
    logic [31:0] w[44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [7:0]  a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = p[127-8*n -: 8] ^ k[127-8*n -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int n = 0; n < 16; n++) t[n] = sbox_t[s[n]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
          s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] ^= w[4*rnd+c][31-8*r -: 8];
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    logic [7:0] x;
    for (int v = 0; v < 256; v++) begin
      x   = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        sbox_t[v][i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ (((8'h63) >> i) & 1'b1);
    end
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: got timeout expected event", name);
  endtask

  // Called at posedge+1; the block is accepted on the following clock edge.
  task automatic applyStimulus(input logic [127:0] k, input logic [127:0] p, input logic [127:0] exp);
    exp_t e;
    int   waitc;
    waitc    = 0;
    in_valid = 1'b1;
    key      = k;
    blockin  = p;
    while (!in_ready && waitc < 300) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!in_ready) begin
      timeoutFail("accept_wait");
      in_valid = 1'b0;
      return;
    end
    e.ct    = exp;
    e.acc   = cyc;
    acc_cyc = cyc;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    key      = '1;
    blockin  = '1;
  endtask

  task automatic waitDrain();
    int waitc;
    waitc = 0;
    while (sb_q.size() != 0 && waitc < 400) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (sb_q.size() != 0) timeoutFail("drain_wait");
  endtask

  task automatic waitRound(input logic [3:0] r);
    int waitc;
    waitc = 0;
    while (round_idx != r && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (round_idx != r) timeoutFail("round_wait");
  endtask

  task automatic flushScoreboard();
    sb_q.delete();
    acc_cyc = -1;
  endtask

  // Monitor: round index timing, status flags, latency and ciphertext against the scoreboard.
  always @(negedge clk) begin
    int d;
    int exp_ridx;
    if (nRst) begin
      d        = cyc - acc_cyc;
      exp_ridx = (acc_cyc >= 0 && d >= 1 && d <= 10) ? d : 0;
      checkOutput("round_idx", 128'(round_idx), 128'(exp_ridx));
      if (exp_ridx != 0) checkOutput("flags_in_round", {busy, in_ready, out_valid}, 3'b100);
      if (out_valid) begin
        checkOutput("flags_done", {busy, in_ready}, 2'b10);
        if (sb_q.size() == 0) begin
          checkOutput("spurious_out_valid", 128'(out_valid), 128'(0));
        end else begin
          if (d == 11) checkOutput("latency", 128'(cyc), 128'(sb_q[0].acc + 11));
          else if (d < 11) checkOutput("early_out_valid", 128'(d), 128'(11));
          checkOutput("ciphertext", blockout, sb_q[0].ct);
          if (out_ready) begin
            last_ct = sb_q[0].ct;
            void'(sb_q.pop_front());
          end
        end
      end else begin
        checkOutput("blockout_hold", blockout, last_ct);
      end
    end
  end

  initial begin
    int waitc;
    logic [127:0] rk, rp;
    n_checks   = 0;
    n_fail     = 0;
    acc_cyc    = -1;
    last_ct    = '0;
    ready_mode = 1;
    out_ready  = 1'b1;
    nRst       = 1'b0;
    in_valid   = 1'b0;
    key        = '0;
    blockin    = '0;
`ifdef JB_AES_ITER_ABORT_EN
    abort      = 1'b0;
`endif
    buildSbox();
    checkOutput("model_c1", aes_ref(C1_KEY, C1_PT), C1_CT);
    #1;
    checkOutput("reset_flags", {in_ready, out_valid, busy}, 3'b100);
    checkOutput("reset_round_idx", 128'(round_idx), 128'(0));
    checkOutput("reset_blockout", blockout, 128'(0));
    repeat (2) @(posedge clk);
    #1 nRst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] FIPS-197 C.1 and App.B vectors");
    applyStimulus(C1_KEY, C1_PT, C1_CT);
    waitDrain();
    applyStimulus(B_KEY, B_PT, B_CT);
    waitDrain();

    $display("[TB] backpressure");
    ready_mode = 0;
    applyStimulus(C1_KEY, C1_PT, C1_CT);
    waitc = 0;
    while (!out_valid && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!out_valid) timeoutFail("out_valid_wait");
    in_valid = 1'b1;
    key      = B_KEY;
    blockin  = B_PT;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
      checkOutput("bp_out_valid", 128'(out_valid), 128'(1));
    end
    ready_mode = 1;
    @(posedge clk); #1;
    ready_mode = 0;
    checkOutput("bp_idle_after_retire", {in_ready, out_valid}, 2'b10);
    applyStimulus(B_KEY, B_PT, B_CT);
    ready_mode = 1;
    waitDrain();

    $display("[TB] reset mid-round");
    applyStimulus(C1_KEY, C1_PT, C1_CT);
    waitRound(4'd5);
    nRst = 1'b0;
    #1;
    flushScoreboard();
    last_ct = '0;
    checkOutput("rst_mid_flags", {in_ready, out_valid, busy}, 3'b100);
    checkOutput("rst_mid_round_idx", 128'(round_idx), 128'(0));
    checkOutput("rst_mid_blockout", blockout, 128'(0));
    @(posedge clk); #1;
    nRst = 1'b1;
    @(posedge clk); #1;
    applyStimulus(C1_KEY, C1_PT, C1_CT);
    waitDrain();

    $display("[TB] random blocks");
    ready_mode = 2;
    for (int i = 0; i < 10; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(rk, rp, aes_ref(rk, rp));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    ready_mode = 1;
    waitDrain();

`ifdef JB_AES_ITER_ABORT_EN
    $display("[TB] abort");
    applyStimulus(C1_KEY, C1_PT, C1_CT);
    waitRound(4'd7);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    flushScoreboard();
    checkOutput("abort7_flags", {in_ready, out_valid, busy}, 3'b100);
    checkOutput("abort7_round_idx", 128'(round_idx), 128'(0));
    applyStimulus(B_KEY, B_PT, B_CT);
    waitRound(4'd10);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    flushScoreboard();
    checkOutput("abort10_flags", {in_ready, out_valid, busy}, 3'b100);
    checkOutput("abort10_blockout", blockout, last_ct);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(C1_KEY, C1_PT, C1_CT);
    waitDrain();
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
